// File: rtl/id_stage.sv
// Instruction-decode stage of the 5-stage RV32I pipeline.
// Decodes the IF/ID instruction, bypasses same-cycle writeback data around
// the register file, detects load-use hazards and holds the ID/EX register.
module id_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      ra1,
  output logic [4:0]      ra2,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic            wb_we,
  input  logic [4:0]      wb_wa,
  input  logic [XLEN-1:0] wb_wd,
  input  logic            flush,
  output logic            stall_if,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src_imm,
  output logic            ex_alu_src_pc,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [3:0]      alu_op;
    logic            alu_src_imm;
    logic            alu_src_pc;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            branch;
    logic            jump;
    logic            illegal;
  } idex_t;

  // ALU op for R-type and I-ALU; bit 30 selects SUB (R only) and SRA/SRAI.
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic b30,
                                         input logic is_r);
    logic [3:0] op;
    case (f3)
      3'd0:    op = (is_r && b30) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = b30 ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // x0 reads as zero; otherwise a same-cycle writeback to the index wins.
  function automatic logic [XLEN-1:0] bypass(input logic [4:0] idx,
                                             input logic [XLEN-1:0] rf,
                                             input logic we, input logic [4:0] wa,
                                             input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] v;
    if (idx == 5'd0)             v = '0;
    else if (we && (wa == idx))  v = wd;
    else                         v = rf;
    return v;
  endfunction

  logic [6:0] opc;
  logic       use_rs1;
  logic       use_rs2;
  logic       hazard;
  idex_t      dec_p0;
  idex_t      idex_p1;

  logic signed [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc = if_instr[6:0];
  assign ra1 = if_instr[19:15];
  assign ra2 = if_instr[24:20];

  assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
  assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                  if_instr[11:8], 1'b0};
  assign imm_u = {if_instr[31:12], 12'b0};
  assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                  if_instr[30:21], 1'b0};

  // Stage p0: combinational decode of the IF/ID instruction.
  always_comb begin
    dec_p0          = '0;
    use_rs1         = 1'b0;
    use_rs2         = 1'b0;
    dec_p0.valid    = 1'b1;
    dec_p0.pc       = if_pc;
    dec_p0.rs1      = ra1;
    dec_p0.rs2      = ra2;
    dec_p0.rd       = if_instr[11:7];
    dec_p0.funct3   = if_instr[14:12];
    dec_p0.rs1_data = bypass(ra1, rd1, wb_we, wb_wa, wb_wd);
    dec_p0.rs2_data = bypass(ra2, rd2, wb_we, wb_wa, wb_wd);
    case (opc)
      OP_R: begin
        dec_p0.alu_op    = alu_dec(if_instr[14:12], if_instr[30], 1'b1);
        dec_p0.reg_write = 1'b1;
        use_rs1          = 1'b1;
        use_rs2          = 1'b1;
      end
      OP_IMM: begin
        dec_p0.alu_op      = alu_dec(if_instr[14:12], if_instr[30], 1'b0);
        dec_p0.alu_src_imm = 1'b1;
        dec_p0.imm         = imm_i;
        dec_p0.reg_write   = 1'b1;
        use_rs1            = 1'b1;
      end
      OP_LOAD: begin
        dec_p0.alu_src_imm = 1'b1;
        dec_p0.imm         = imm_i;
        dec_p0.mem_read    = 1'b1;
        dec_p0.reg_write   = 1'b1;
        use_rs1            = 1'b1;
      end
      OP_STORE: begin
        dec_p0.alu_src_imm = 1'b1;
        dec_p0.imm         = imm_s;
        dec_p0.mem_write   = 1'b1;
        use_rs1            = 1'b1;
        use_rs2            = 1'b1;
      end
      OP_BRANCH: begin
        dec_p0.alu_op = ALU_SUB;
        dec_p0.imm    = imm_b;
        dec_p0.branch = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_JAL: begin
        dec_p0.imm        = imm_j;
        dec_p0.alu_src_pc = 1'b1;
        dec_p0.jump       = 1'b1;
        dec_p0.reg_write  = 1'b1;
      end
      OP_JALR: begin
        dec_p0.imm        = imm_i;
        dec_p0.alu_src_pc = 1'b1;
        dec_p0.jump       = 1'b1;
        dec_p0.reg_write  = 1'b1;
        use_rs1           = 1'b1;
      end
      OP_AUIPC: begin
        dec_p0.imm         = imm_u;
        dec_p0.alu_src_imm = 1'b1;
        dec_p0.alu_src_pc  = 1'b1;
        dec_p0.reg_write   = 1'b1;
      end
      OP_LUI: begin
        dec_p0.alu_op      = ALU_PASSB;
        dec_p0.imm         = imm_u;
        dec_p0.alu_src_imm = 1'b1;
        dec_p0.reg_write   = 1'b1;
      end
      default: dec_p0.illegal = 1'b1;
    endcase
    if (dec_p0.rd == 5'd0) dec_p0.reg_write = 1'b0;
  end

  // A load in EX whose destination feeds this instruction forces one bubble.
  assign hazard = if_valid && idex_p1.valid && idex_p1.mem_read && (idex_p1.rd != 5'd0) &&
                  ((use_rs1 && (idex_p1.rd == ra1)) || (use_rs2 && (idex_p1.rd == ra2)));

  assign stall_if = hazard && !flush;

  // Stage p1: ID/EX register; flush, hazard and empty slots all insert a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              idex_p1 <= '0;
    else if (flush || hazard || !if_valid) idex_p1 <= '0;
    else                                  idex_p1 <= dec_p0;
  end

  assign ex_valid       = idex_p1.valid;
  assign ex_pc          = idex_p1.pc;
  assign ex_rs1_data    = idex_p1.rs1_data;
  assign ex_rs2_data    = idex_p1.rs2_data;
  assign ex_imm         = idex_p1.imm;
  assign ex_rs1         = idex_p1.rs1;
  assign ex_rs2         = idex_p1.rs2;
  assign ex_rd          = idex_p1.rd;
  assign ex_funct3      = idex_p1.funct3;
  assign ex_alu_op      = idex_p1.alu_op;
  assign ex_alu_src_imm = idex_p1.alu_src_imm;
  assign ex_alu_src_pc  = idex_p1.alu_src_pc;
  assign ex_mem_read    = idex_p1.mem_read;
  assign ex_mem_write   = idex_p1.mem_write;
  assign ex_reg_write   = idex_p1.reg_write;
  assign ex_branch      = idex_p1.branch;
  assign ex_jump        = idex_p1.jump;
  assign ex_illegal     = idex_p1.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        flush;
  logic        stall_if;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src_imm, ex_alu_src_pc, ex_mem_read, ex_mem_write;
  logic        ex_reg_write, ex_branch, ex_jump, ex_illegal;

  id_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .flush(flush), .stall_if(stall_if),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_alu_op(ex_alu_op),
    .ex_alu_src_imm(ex_alu_src_imm), .ex_alu_src_pc(ex_alu_src_pc),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  op;
    logic        simm, spc, mr, mw, rw, br, jp, ill;
  } ex_t;

  ex_t act;
  always_comb begin
    act       = '0;
    act.valid = ex_valid;  act.pc = ex_pc;  act.d1 = ex_rs1_data;  act.d2 = ex_rs2_data;
    act.imm   = ex_imm;    act.rs1 = ex_rs1; act.rs2 = ex_rs2;  act.rd = ex_rd;
    act.f3    = ex_funct3; act.op = ex_alu_op; act.simm = ex_alu_src_imm;
    act.spc   = ex_alu_src_pc; act.mr = ex_mem_read; act.mw = ex_mem_write;
    act.rw    = ex_reg_write;  act.br = ex_branch; act.jp = ex_jump; act.ill = ex_illegal;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [191:0] a, input logic [191:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned alu_base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  function automatic logic [31:0] rdval(input logic [4:0] idx, input logic [31:0] rf,
                                        input logic we, input logic [4:0] wa,
                                        input logic [31:0] wd);
    if (idx == 0) return 32'd0;
    if (we && wa == idx) return wd;
    return rf;
  endfunction

  function automatic ex_t model(input logic [31:0] ins, input logic [31:0] pc,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd);
    ex_t e;
    logic signed [31:0] si;
    logic [31:0] sx;
    logic [3:0] aop;
    si  = ins;
    sx  = si >>> 31;
    aop = 4'(alu_base[ins[14:12]]);
    if (ins[14:12] == 3'd5 && ins[30]) aop = 4'd7;
    e = '0;
    e.valid = 1'b1; e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.f3 = ins[14:12];
    e.d1 = rdval(ins[19:15], r1, we, wa, wd);
    e.d2 = rdval(ins[24:20], r2, we, wa, wd);
    case (ins[6:0])
      7'h33: begin e.op = (ins[14:12] == 0 && ins[30]) ? 4'd1 : aop; e.rw = 1; end
      7'h13: begin e.op = aop; e.simm = 1; e.rw = 1; e.imm = 32'(si >>> 20); end
      7'h03: begin e.mr = 1; e.simm = 1; e.rw = 1; e.imm = 32'(si >>> 20); end
      7'h23: begin e.mw = 1; e.simm = 1;
               e.imm = (32'(si >>> 25) << 5) | 32'(ins[11:7]); end
      7'h63: begin e.br = 1; e.op = 4'd1;
               e.imm = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) |
                       (32'(ins[11:8]) << 1); end
      7'h6F: begin e.jp = 1; e.spc = 1; e.rw = 1;
               e.imm = (sx << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) |
                       (32'(ins[30:21]) << 1); end
      7'h67: begin e.jp = 1; e.spc = 1; e.rw = 1; e.imm = 32'(si >>> 20); end
      7'h17: begin e.spc = 1; e.simm = 1; e.rw = 1; e.imm = ins & 32'hFFFFF000; end
      7'h37: begin e.op = 4'd10; e.simm = 1; e.rw = 1; e.imm = ins & 32'hFFFFF000; end
      default: e.ill = 1;
    endcase
    if (e.rd == 0) e.rw = 0;
    return e;
  endfunction

  function automatic logic uses1(input logic [6:0] o);
    return o inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction
  function automatic logic uses2(input logic [6:0] o);
    return o inside {7'h33, 7'h23, 7'h63};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                       input logic fl, input logic [31:0] r1, input logic [31:0] r2,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if_instr = ins; if_pc = pc; if_valid = v; flush = fl;
    rd1 = r1; rd2 = r2; wb_we = we; wb_wa = wa; wb_wd = wd;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] instr, pc, rd1;
    logic        wbwe;
    logic [4:0]  wbwa;
    logic [31:0] wbwd, imm;
    logic [3:0]  op;
    logic        rw, br, mw, ill;
    logic [31:0] d1;
  } vec_t;

  vec_t tbl [12];

  localparam logic [31:0] LW_X2  = 32'h0000A103;
  localparam logic [31:0] ADD_X3 = 32'h004101B3;
  localparam logic [31:0] LW_X0  = 32'h0000A003;
  localparam logic [31:0] ADD_X0 = 32'h004001B3;

  ex_t exp_q, exp_n;
  logic hz, exp_stall;

  initial begin
    tbl[0]  = '{32'hFFD08293, 32'h100, 32'h11, 0, 0, 0, 32'hFFFFFFFD, 0, 1, 0, 0, 0, 32'h11};
    tbl[1]  = '{32'h00038093, 32'h104, 32'h0, 1, 7, 32'hDEADBEEF, 0, 0, 1, 0, 0, 0, 32'hDEADBEEF};
    tbl[2]  = '{32'h00038093, 32'h108, 32'h0, 1, 0, 32'hDEADBEEF, 0, 0, 1, 0, 0, 0, 32'h0};
    tbl[3]  = '{32'hFE208EE3, 32'h10C, 32'h22, 0, 0, 0, 32'hFFFFFFFC, 1, 0, 1, 0, 0, 32'h22};
    tbl[4]  = '{32'h0000007F, 32'h110, 32'h5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0};
    tbl[5]  = '{32'h403100B3, 32'h114, 32'h33, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h33};
    tbl[6]  = '{32'h40315093, 32'h118, 32'h33, 0, 0, 0, 32'h403, 7, 1, 0, 0, 0, 32'h33};
    tbl[7]  = '{32'h123450B7, 32'h11C, 32'h44, 0, 0, 0, 32'h12345000, 10, 1, 0, 0, 0, 32'h44};
    tbl[8]  = '{32'hFE20AC23, 32'h120, 32'h66, 0, 0, 0, 32'hFFFFFFF8, 0, 0, 0, 1, 0, 32'h66};
    tbl[9]  = '{32'h008000EF, 32'h124, 32'h7, 0, 0, 0, 32'h8, 0, 1, 0, 0, 0, 32'h0};
    tbl[10] = '{32'h00500013, 32'h128, 32'h99, 0, 0, 0, 32'h5, 0, 0, 0, 0, 0, 32'h0};
    tbl[11] = '{ADD_X0,       32'h12C, 32'h77, 1, 0, 32'hFFFF, 0, 0, 1, 0, 0, 0, 32'h0};

    // Power-on reset
    rst = 1'b1;
    drive(32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {act, stall_if}, '0);
    @(negedge clk) rst = 1'b0;

    // Directed decode vectors
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].instr, tbl[i].pc, 1, 0, tbl[i].rd1, 32'h0, tbl[i].wbwe, tbl[i].wbwa,
            tbl[i].wbwd);
      #1 chk($sformatf("vec%0d_stall", i), stall_if, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i),
          {ex_valid, ex_pc, ex_imm, ex_alu_op, ex_reg_write, ex_branch, ex_mem_write,
           ex_illegal, ex_rs1_data},
          {1'b1, tbl[i].pc, tbl[i].imm, tbl[i].op, tbl[i].rw, tbl[i].br, tbl[i].mw,
           tbl[i].ill, tbl[i].d1});
      chk($sformatf("vec%0d_model", i), act,
          model(tbl[i].instr, tbl[i].pc, tbl[i].rd1, 32'h0, tbl[i].wbwe, tbl[i].wbwa,
                tbl[i].wbwd));
      @(negedge clk);
    end

    // Load-use: one stall cycle, then the add issues
    drive(LW_X2, 32'h200, 1, 0, 1, 2, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    drive(ADD_X3, 32'h204, 1, 0, 1, 2, 0, 0, 0);
    #1 chk("lu_stall", stall_if, 1'b1);
    @(posedge clk); #1 chk("lu_bubble", ex_valid, 1'b0);
    @(negedge clk); #1 chk("lu_release", stall_if, 1'b0);
    @(posedge clk); #1 chk("lu_issue", {ex_valid, ex_rs1, ex_rd, ex_pc},
                           {1'b1, 5'd2, 5'd3, 32'h204});
    @(negedge clk);

    // lw x0 never creates a hazard
    drive(LW_X0, 32'h300, 1, 0, 1, 2, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    drive(ADD_X0, 32'h304, 1, 0, 1, 2, 0, 0, 0);
    #1 chk("lw_x0_nostall", stall_if, 1'b0);
    @(posedge clk); #1 chk("lw_x0_issue", {ex_valid, ex_pc}, {1'b1, 32'h304});
    @(negedge clk);

    // Flush wins over a simultaneous load-use hazard
    drive(LW_X2, 32'h400, 1, 0, 1, 2, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    drive(ADD_X3, 32'h404, 1, 1, 1, 2, 0, 0, 0);
    #1 chk("flush_stall", stall_if, 1'b0);
    @(posedge clk); #1 chk("flush_bubble", act, '0);
    @(negedge clk);

    // Asynchronous reset mid-stall
    drive(LW_X2, 32'h500, 1, 0, 1, 2, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    drive(ADD_X3, 32'h504, 1, 0, 1, 2, 0, 0, 0);
    #1 chk("rst_pre_stall", {stall_if, ex_valid}, 2'b11);
    #2 rst = 1'b1;
    #1 chk("rst_async", {act, stall_if}, '0);
    @(negedge clk) rst = 1'b0;
    drive(32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized run against the reference model
    exp_q = '0;
    for (int c = 0; c < 600; c++) begin
      logic [31:0] ins;
      logic [6:0]  opl [10];
      logic        v, fl;
      opl = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h17, 7'h37, 7'h7F};
      if (!exp_stall || c == 0) begin
        ins = $urandom;
        ins[6:0]   = opl[$urandom_range(0, 9)];
        if ($urandom_range(0, 3) == 0) ins[6:0] = opl[2];
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        v = ($urandom_range(0, 7) != 0);
      end else begin
        ins = if_instr;
        v   = 1'b1;
      end
      fl = ($urandom_range(0, 7) == 0);
      drive(ins, $urandom, v, fl, $urandom, $urandom, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), $urandom);
      hz = v && exp_q.valid && exp_q.mr && exp_q.rd != 0 &&
           ((uses1(ins[6:0]) && exp_q.rd == ins[19:15]) ||
            (uses2(ins[6:0]) && exp_q.rd == ins[24:20]));
      exp_stall = hz && !fl;
      if (fl || hz || !v) exp_n = '0;
      else exp_n = model(ins, if_pc, rd1, rd2, wb_we, wb_wa, wb_wd);
      #1 chk("rand_stall", stall_if, exp_stall);
      chk("rand_ra", {ra1, ra2}, {ins[19:15], ins[24:20]});
      @(posedge clk); #1;
      chk("rand_ex", act, exp_n);
      exp_q = exp_n;
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Instruction-decode stage of the 5-stage RV32I pipeline. It decodes the fetched instruction, drives the register-file read addresses, and bypasses same-cycle writeback data around the register file. It generates immediates and control, detects load-use hazards, and holds the ID/EX pipeline register consumed by the execute stage. Supports stall (bubble insertion) and flush (branch/jump redirect from EX).

Parameters:
XLEN, 32, datapath width (only 32 supported)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
if_valid  in  1  IF/ID holds a valid instruction
if_instr  in  32  instruction word from IF/ID
if_pc  in  32  PC of if_instr
ra1  out  5  regfile rs1 address (instr[19:15])
ra2  out  5  regfile rs2 address (instr[24:20])
rd1  in  32  regfile read data 1
rd2  in  32  regfile read data 2
wb_we  in  1  writeback write enable (same signal that drives regfile we)
wb_wa  in  5  writeback address
wb_wd  in  32  writeback data
flush  in  1  EX redirect; squash instruction in ID
stall_if  out  1  hold PC and IF/ID this cycle (load-use)
ex_valid  out  1  ID/EX holds a real instruction
ex_pc  out  32  PC
ex_rs1_data  out  32  operand 1
ex_rs2_data  out  32  operand 2
ex_imm  out  32  sign-extended immediate
ex_rs1, ex_rs2, ex_rd  out  5 each  register indices (for EX forwarding)
ex_funct3  out  3  funct3 (branch/load/store size)
ex_alu_op  out  4  ALU operation
ex_alu_src_imm  out  1  operand B = immediate
ex_alu_src_pc  out  1  operand A = PC (AUIPC, JAL, JALR link calc)
ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump  out  1 each  control
ex_illegal  out  1  unsupported opcode seen

Behaviour:
- Reset (async): every ex_* register cleared to 0 immediately. stall_if is then 0.
- Latency: decode is combinational; results register into ID/EX on the next posedge (1 cycle).
- ra1/ra2 are driven combinationally from if_instr bit fields regardless of if_valid.
- WB bypass: if wb_we && wb_wa!=0 && wb_wa==ra1, then operand 1 = wb_wd; otherwise operand 1 = rd1. Same rule for ra2 and operand 2. An index of x0 always yields 0.
- Opcodes:
  - R 0110011 and I-ALU 0010011: ALU op from funct3/funct7[5]. SUB only for R-type. SRAI uses funct7[5].
  - LOAD 0000011, STORE 0100011, JAL 1101111, JALR 1100111, AUIPC 0010111: alu_op = ADD.
  - BRANCH 1100011: alu_op = SUB, branch = 1.
  - LUI 0110111: alu_op = PASSB.
  - Any other opcode: illegal = 1, all other control bits 0, valid = 1.
- alu_op encoding: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10.
- Immediates: I, S, B (bit0 = 0), U (low 12 bits = 0) and J (bit0 = 0) formats, each sign-extended from instr[31].
- reg_write is forced to 0 when rd = 0.
- Register-use flags:
  - rs1 used by R, I-ALU, LOAD, STORE, BRANCH, JALR.
  - rs2 used by R, STORE, BRANCH.
- Load-use hazard (combinational): hazard = if_valid && ex_valid && ex_mem_read && ex_rd!=0 && ((use_rs1 && ex_rd==ra1) || (use_rs2 && ex_rd==ra2)).
- Next-state priority per cycle:
  1. flush: ID/EX <= bubble; stall_if = 0. Flush wins over a simultaneous hazard.
  2. hazard: ID/EX <= bubble; stall_if = 1. The instruction is re-presented the next cycle.
  3. !if_valid: ID/EX <= bubble.
  4. otherwise: ID/EX <= decoded instruction with ex_valid = 1.
- Bubble: all ex_* fields = 0. NOP-equivalent, no side effects.
- Back-to-back hazards are impossible: the bubble clears ex_mem_read, so a load-use stall lasts exactly 1 cycle.
- No internal state beyond the ID/EX register. Reset mid-stall clears the register and releases stall_if.

Test Plan:
- Reset: assert rst mid-cycle with ex_valid = 1 -> all ex_* = 0 immediately, stall_if = 0.
- Decode: addi x5,x1,-3 (0xFFD08293), if_pc = 0x100 -> next cycle:
  - ex_valid = 1, ex_imm = 0xFFFFFFFD, ex_alu_op = 0, ex_alu_src_imm = 1, ex_rd = 5, ex_reg_write = 1, ex_pc = 0x100.
- Load-use: lw x2,0(x1), then add x3,x2,x4 ->
  - while the add is in ID: stall_if = 1 for exactly 1 cycle, ex_valid = 0 for that cycle.
  - add then issues with ex_rs1 = 2.
  - variant add x3,x0,x4 after lw x0: no stall.
- WB bypass: wb_we = 1, wb_wa = 7, wb_wd = 0xDEADBEEF, rd1 = 0, instr reads x7 as rs1 -> ex_rs1_data = 0xDEADBEEF. With wb_wa = 0, ex_rs1_data = 0.
- Flush priority: flush = 1 coincident with a load-use hazard -> stall_if = 0, next ex_valid = 0, all control = 0.
- Immediates/illegal:
  - beq with offset -4 -> ex_imm = 0xFFFFFFFC, ex_branch = 1, ex_alu_op = 1.
  - opcode 0x7F -> ex_illegal = 1, ex_reg_write = 0, ex_mem_write = 0.
